// File: rtl/bus_arbiter_pkg.sv
// ============================================================================
// bus_arbiter_pkg : shared state encoding, default widths, next-state helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package bus_arbiter_pkg;

  localparam int c_def_addr_w = 16;
  localparam int c_def_data_w = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  // last_gnt names the master granted most recently; a tie goes to the other one.
  function automatic arb_state_e arb_next_state(
    input arb_state_e st,
    input logic       req0,
    input logic       req1,
    input logic       last_gnt,
    input logic       hold_max
  );
    arb_state_e nxt;
    nxt = ST_IDLE;
    case (st)
      ST_IDLE: begin
        if (req0 && req1) nxt = last_gnt ? ST_GNT0 : ST_GNT1;
        else if (req0)    nxt = ST_GNT0;
        else if (req1)    nxt = ST_GNT1;
        else              nxt = ST_IDLE;
      end
      ST_GNT0: begin
        if (req0) nxt = (hold_max && req1) ? ST_GNT1 : ST_GNT0;
        else      nxt = req1 ? ST_GNT1 : ST_IDLE;
      end
      ST_GNT1: begin
        if (req1) nxt = (hold_max && req0) ? ST_GNT0 : ST_GNT1;
        else      nxt = req0 ? ST_GNT0 : ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_hold_counter.sv
// ============================================================================
// arb_hold_counter : saturating grant-hold counter with synchronous clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_hold_counter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// bus_arbiter : two-master to one-bus arbiter, alternating ties, hold-limited
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = c_def_addr_w,
  parameter int DATA_W   = c_def_data_w,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic [DATA_W-1:0] m0_din,
  output logic [DATA_W-1:0] m1_din,
  output logic              b_req,
  output logic              b_wr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_dout,
  input  logic [DATA_W-1:0] b_din
);

  localparam int c_cnt_w = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_e         r_state;
  arb_state_e         w_next_state;
  logic               r_last_gnt;
  logic [c_cnt_w-1:0] w_hold_cnt;
  logic               w_hold_max;

  assign w_hold_max   = (w_hold_cnt == c_cnt_w'(MAX_HOLD - 1));
  assign w_next_state = arb_next_state(r_state, m0_req, m1_req, r_last_gnt, w_hold_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == ST_GNT0)      r_last_gnt <= 1'b0;
      else if (w_next_state == ST_GNT1) r_last_gnt <= 1'b1;
    end
  end

  // Any change of owner (including to/from idle) restarts the hold window.
  arb_hold_counter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (c_cnt_w)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_next_state != r_state),
    .i_en    (r_state != ST_IDLE),
    .o_cnt   (w_hold_cnt)
  );

  assign m0_grant = (r_state == ST_GNT0);
  assign m1_grant = (r_state == ST_GNT1);

  always_comb begin
    b_req  = 1'b0;
    b_wr   = 1'b0;
    b_addr = '0;
    b_dout = '0;
    m0_din = '0;
    m1_din = '0;
    case (r_state)
      ST_GNT0: begin
        b_req  = m0_req;
        b_wr   = m0_wr;
        b_addr = m0_addr;
        b_dout = m0_dout;
        m0_din = b_din;
      end
      ST_GNT1: begin
        b_req  = m1_req;
        b_wr   = m1_wr;
        b_addr = m1_addr;
        b_dout = m1_dout;
        m1_din = b_din;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// tb_bus_arbiter : table vectors, directed corner sequences, random vs. model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 64;
  localparam int MAX_HOLD = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              m0_req = 1'b0, m0_wr = 1'b0;
  logic              m1_req = 1'b0, m1_wr = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [DATA_W-1:0] m0_dout = '0, m1_dout = '0, b_din = '0;
  logic              m0_grant, m1_grant, b_req, b_wr;
  logic [DATA_W-1:0] m0_din, m1_din, b_dout;
  logic [ADDR_W-1:0] b_addr;

  bus_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_wr    (m0_wr),
    .m0_addr  (m0_addr),
    .m0_dout  (m0_dout),
    .m1_req   (m1_req),
    .m1_wr    (m1_wr),
    .m1_addr  (m1_addr),
    .m1_dout  (m1_dout),
    .m0_grant (m0_grant),
    .m1_grant (m1_grant),
    .m0_din   (m0_din),
    .m1_din   (m1_din),
    .b_req    (b_req),
    .b_wr     (b_wr),
    .b_addr   (b_addr),
    .b_dout   (b_dout),
    .b_din    (b_din)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: owner -1 = nobody, 0/1 = master index; held = cycles since taking the bus.
  int mdl_owner = -1;
  int mdl_held  = 0;
  int mdl_last  = 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_edge();
    int nxt;
    logic rx, ry;
    if (reset) begin
      mdl_owner = -1;
      mdl_held  = 0;
      mdl_last  = 1;
      return;
    end
    if (mdl_owner < 0) begin
      if (m0_req && m1_req) nxt = 1 - mdl_last;
      else if (m0_req)      nxt = 0;
      else if (m1_req)      nxt = 1;
      else                  nxt = -1;
    end else begin
      rx = (mdl_owner == 0) ? m0_req : m1_req;
      ry = (mdl_owner == 0) ? m1_req : m0_req;
      if (!rx)                                nxt = ry ? 1 - mdl_owner : -1;
      else if (ry && mdl_held >= MAX_HOLD - 1) nxt = 1 - mdl_owner;
      else                                    nxt = mdl_owner;
    end
    if (nxt != mdl_owner)  mdl_held = 0;
    else if (nxt >= 0)     mdl_held++;
    if (nxt >= 0) mdl_last = nxt;
    mdl_owner = nxt;
  endtask

  function automatic logic [211:0] exp_vec();
    logic              g0, g1, rq, wr;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] dt, d0, d1;
    g0 = (mdl_owner == 0);
    g1 = (mdl_owner == 1);
    rq = g0 ? m0_req  : (g1 ? m1_req  : 1'b0);
    wr = g0 ? m0_wr   : (g1 ? m1_wr   : 1'b0);
    ad = g0 ? m0_addr : (g1 ? m1_addr : '0);
    dt = g0 ? m0_dout : (g1 ? m1_dout : '0);
    d0 = g0 ? b_din : '0;
    d1 = g1 ? b_din : '0;
    return {g0, g1, rq, wr, ad, dt, d0, d1};
  endfunction

  function automatic logic [211:0] act_vec();
    return {m0_grant, m1_grant, b_req, b_wr, b_addr, b_dout, m0_din, m1_din};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", act_vec(), exp_vec());
  endtask

  typedef struct {
    logic        rst;
    logic        r0;
    logic        r1;
    logic        g0;
    logic        g1;
    logic [15:0] baddr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n_g0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0010};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0020};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0020};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0020};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

    m0_addr = 16'h0010;
    m1_addr = 16'h0020;
    for (int i = 0; i < 12; i++) begin
      reset  = vecs[i].rst;
      m0_req = vecs[i].r0;
      m1_req = vecs[i].r1;
      tick();
      chk($sformatf("tbl[%0d]", i), {m0_grant, m1_grant, b_addr},
          {vecs[i].g0, vecs[i].g1, vecs[i].baddr});
    end

    // Both request together after reset: m0 keeps the bus for MAX_HOLD cycles, then m1.
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    tick();
    reset = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    tick();
    n_g0 = 0;
    for (int i = 0; i < 40 && m0_grant; i++) begin
      n_g0++;
      tick();
    end
    chk("preempt_len", 32'(n_g0), 32'(MAX_HOLD));
    chk("preempt_g1", m1_grant, 1'b1);

    // Read return and isolation of the ungranted master while m1 owns the bus.
    reset = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    tick();
    reset = 1'b0; m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h1234;
    m1_dout = 64'h1111_2222_3333_4444;
    tick();
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h7000; m0_dout = 64'hFFFF_0000_FFFF_0000;
    b_din  = 64'hDEADBEEF;
    tick();
    chk("rd_m1_din", m1_din, 64'hDEADBEEF);
    chk("rd_m0_din", m0_din, 64'h0);
    chk("iso_b_wr", b_wr, 1'b0);
    chk("iso_b_addr", b_addr, 16'h1234);
    m1_wr = 1'b1;
    tick();
    chk("iso_b_wr1", {m1_grant, b_wr, b_dout}, {1'b1, 1'b1, 64'h1111_2222_3333_4444});

    // Reset while m1 is granted, then simultaneous requests go to m0.
    reset = 1'b1;
    tick();
    chk("rst_mid_zero", act_vec(), 212'h0);
    reset = 1'b0;
    tick();
    chk("rst_then_tie", {m0_grant, m1_grant, b_addr}, {1'b1, 1'b0, 16'h7000});
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    chk("drop_both", {m0_grant, m1_grant, b_req}, 3'b000);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 59) == 0);
      m0_req  = ($urandom_range(0, 9) < 7);
      m1_req  = ($urandom_range(0, 9) < 6);
      m0_wr   = 1'($urandom);
      m1_wr   = 1'($urandom);
      m0_addr = 16'($urandom);
      m1_addr = 16'($urandom);
      m0_dout = {$urandom, $urandom};
      m1_dout = {$urandom, $urandom};
      b_din   = {$urandom, $urandom};
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
